// File: rtl/dsp_mac_pipe.sv
// Four-stage pre-add / multiply / post-add MAC pipeline with per-sample OPMODE,
// global stall, optional post-adder saturation and a sticky overflow flag.
module dsp_mac_pipe #(
  parameter int unsigned AW         = 18,
  parameter int unsigned BW         = 18,
  parameter int unsigned PW         = 48,
  parameter bit          CARRYINSEL = 1'b0,
  parameter bit          SAT        = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  input  logic             STALL,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic [BW-1:0]    D,
  input  logic [PW-1:0]    C,
  input  logic [PW-1:0]    PCIN,
  input  logic [7:0]       OPMODE,
  input  logic             CARRYIN,
  input  logic             CLR_OVF,
  output logic [BW-1:0]    BCOUT,
  output logic [AW+BW-1:0] M,
  output logic [PW-1:0]    P,
  output logic [PW-1:0]    PCOUT,
  output logic             CARRYOUT,
  output logic             OUT_VALID,
  output logic             OVF
);

  localparam int unsigned MW  = AW + BW;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned PMW = 6;

  // Stage-1 input registers
  logic [AW-1:0]  a1;
  logic [BW-1:0]  b1, d1;
  logic [PW-1:0]  c1, pcin1;
  logic [7:0]     op1;
  logic           cin1, v1;

  // Stage-2 / stage-3 side-band carried alongside BCOUT and M
  logic [AW-1:0]  a2;
  logic [PW-1:0]  c2, pcin2, c3, pcin3;
  logic [PMW-1:0] pm1, pm2, pm3;
  logic           cin2, cin3, v2, v3;

  logic [BW-1:0]  bc_next;
  logic [MW-1:0]  m_next;
  logic [PW-1:0]  x_mux, z_mux, p_next;
  logic [SW-1:0]  post_sum;
  logic           cin_sel, clamp, p_update;

  // Post-adder mode fields once the pre-adder is done: {sub, carry, zsel, xsel}
  assign pm1      = {op1[7], op1[5], op1[3:0]};
  assign p_update = v3 && !STALL;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      op1   <= '0;
      cin1  <= 1'b0;
      v1    <= 1'b0;
    end else if (!STALL) begin
      a1    <= A;
      b1    <= B;
      d1    <= D;
      c1    <= C;
      pcin1 <= PCIN;
      op1   <= OPMODE;
      cin1  <= CARRYIN;
      v1    <= IN_VALID;
    end
  end

  // Pre-adder: pass B, or D+B / D-B, wrapping at BW bits
  always_comb begin
    bc_next = b1;
    if (op1[4]) begin
      bc_next = op1[6] ? BW'(d1 - b1) : BW'(d1 + b1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      BCOUT <= '0;
      a2    <= '0;
      c2    <= '0;
      pcin2 <= '0;
      pm2   <= '0;
      cin2  <= 1'b0;
      v2    <= 1'b0;
    end else if (!STALL) begin
      BCOUT <= bc_next;
      a2    <= a1;
      c2    <= c1;
      pcin2 <= pcin1;
      pm2   <= pm1;
      cin2  <= cin1;
      v2    <= v1;
    end
  end

  assign m_next = MW'(BCOUT) * MW'(a2);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      M     <= '0;
      c3    <= '0;
      pcin3 <= '0;
      pm3   <= '0;
      cin3  <= 1'b0;
      v3    <= 1'b0;
    end else if (!STALL) begin
      M     <= m_next;
      c3    <= c2;
      pcin3 <= pcin2;
      pm3   <= pm2;
      cin3  <= cin2;
      v3    <= v2;
    end
  end

  // X / Z operand selection for the post-adder
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    case (pm3[1:0])
      2'd0:    x_mux = '0;
      2'd1:    x_mux = PW'(M);
      2'd2:    x_mux = P;
      default: x_mux = c3;
    endcase
    case (pm3[3:2])
      2'd0:    z_mux = '0;
      2'd1:    z_mux = pcin3;
      2'd2:    z_mux = P;
      default: z_mux = c3;
    endcase
  end

  // Post-adder in PW+1 bits; the top bit is carry on add, borrow on subtract
  always_comb begin
    cin_sel = CARRYINSEL ? cin3 : pm3[4];
    if (pm3[5]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + SW'(cin_sel));
    end else begin
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + SW'(cin_sel);
    end
    clamp  = SAT && post_sum[PW];
    p_next = post_sum[PW-1:0];
    if (clamp) begin
      p_next = pm3[5] ? '0 : '1;
    end
  end

  // Result stage only moves on valid samples so feedback accumulates cleanly
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      P         <= '0;
      PCOUT     <= '0;
      CARRYOUT  <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (!STALL) begin
      OUT_VALID <= v3;
      if (p_update) begin
        P        <= p_next;
        PCOUT    <= p_next;
        CARRYOUT <= post_sum[PW];
      end
    end
  end

  // Sticky overflow: a clamp on this update outranks a simultaneous clear
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OVF <= 1'b0;
    end else if (!STALL) begin
      if (p_update && clamp) begin
        OVF <= 1'b1;
      end else if (CLR_OVF) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a wrap/internal-carry instance and a
// saturating/external-carry instance share one stimulus stream.
module tb_dsp_mac_pipe;

  localparam int unsigned AW = 18;
  localparam int unsigned BW = 18;
  localparam int unsigned PW = 48;
  localparam int unsigned MW = AW + BW;
  localparam logic [PW-1:0] ALL1 = '1;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b, d;
    logic [PW-1:0] c, pcin;
    logic [7:0]    op;
    logic          cin;
  } smp_t;

  typedef struct {
    logic [PW-1:0] p;
    logic          co;
    logic [MW-1:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, stall = 1'b0, clr_ovf = 1'b0, carryin = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0, d = '0;
  logic [PW-1:0] c = '0, pcin = '0;
  logic [7:0] opmode = '0;

  logic [BW-1:0] bcout0, bcout1;
  logic [MW-1:0] m0, m1, mprev0, mprev1;
  logic [PW-1:0] p0, p1, pcout0, pcout1;
  logic co0, co1, ov0, ov1, ovf0, ovf1;
  logic adv = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  logic [PW-1:0] acc0 = '0, acc1 = '0;
  bit sticky1 = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .CARRYINSEL(1'b0), .SAT(1'b0)) u0 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .STALL(stall), .A(a), .B(b), .D(d),
    .C(c), .PCIN(pcin), .OPMODE(opmode), .CARRYIN(carryin), .CLR_OVF(clr_ovf),
    .BCOUT(bcout0), .M(m0), .P(p0), .PCOUT(pcout0), .CARRYOUT(co0),
    .OUT_VALID(ov0), .OVF(ovf0));

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .CARRYINSEL(1'b1), .SAT(1'b1)) u1 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .STALL(stall), .A(a), .B(b), .D(d),
    .C(c), .PCIN(pcin), .OPMODE(opmode), .CARRYIN(carryin), .CLR_OVF(clr_ovf),
    .BCOUT(bcout1), .M(m1), .P(p1), .PCOUT(pcout1), .CARRYOUT(co1),
    .OUT_VALID(ov1), .OVF(ovf1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-sample arithmetic on 64-bit integers
  function automatic exp_t ref_model(input smp_t s, input logic [PW-1:0] p_prev,
                                     input bit sat, input bit csel, output bit clamp);
    longint unsigned full, bmod, bc, m, x, z, ci, r;
    bit carry;
    exp_t e;
    full = 64'd1 << PW;
    bmod = 64'd1 << BW;
    if (!s.op[4])     bc = 64'(s.b);
    else if (s.op[6]) bc = (64'(s.d) + bmod - 64'(s.b)) % bmod;
    else              bc = (64'(s.d) + 64'(s.b)) % bmod;
    m = bc * 64'(s.a);
    case (s.op[1:0])
      2'd0: x = 0;
      2'd1: x = m;
      2'd2: x = 64'(p_prev);
      default: x = 64'(s.c);
    endcase
    case (s.op[3:2])
      2'd0: z = 0;
      2'd1: z = 64'(s.pcin);
      2'd2: z = 64'(p_prev);
      default: z = 64'(s.c);
    endcase
    ci = csel ? 64'(s.cin) : 64'(s.op[5]);
    if (!s.op[7]) begin
      r = z + x + ci;
      carry = (r >= full);
      r = r % full;
    end else begin
      carry = (z < x + ci);
      r = (z + 2 * full - x - ci) % full;
    end
    clamp = sat && carry;
    if (clamp) r = s.op[7] ? 64'd0 : full - 1;
    e.p  = PW'(r);
    e.co = carry;
    e.m  = MW'(m);
    return e;
  endfunction

  task automatic issue(input smp_t s);
    exp_t e0, e1;
    bit cl0, cl1;
    e0 = ref_model(s, acc0, 1'b0, 1'b0, cl0);
    e1 = ref_model(s, acc1, 1'b1, 1'b1, cl1);
    acc0 = e0.p;
    acc1 = e1.p;
    if (cl1) sticky1 = 1'b1;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic step(input bit v, input bit st, input bit clr, input smp_t s);
    in_valid = v; stall = st; clr_ovf = clr;
    a = s.a; b = s.b; d = s.d; c = s.c; pcin = s.pcin; opmode = s.op; carryin = s.cin;
    if (v && !st) issue(s);
    @(posedge clk);
    #1;
  endtask

  function automatic smp_t mk(input longint unsigned va, vb, vd, vc, input logic [7:0] op);
    smp_t s;
    s.a = AW'(va); s.b = BW'(vb); s.d = BW'(vd); s.c = PW'(vc);
    s.pcin = '0; s.op = op; s.cin = 1'b0;
    return s;
  endfunction

  task automatic flush_model();
    q0.delete(); q1.delete();
    acc0 = '0; acc1 = '0; sticky1 = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; stall = 1'b0; clr_ovf = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic mon(input int inst, input logic [PW-1:0] p, pc, input logic co,
                     input logic [MW-1:0] mp);
    exp_t e;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid%0d: pulse with no sample pending, P=%0h", inst, p);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("sb_p%0d", inst), 64'(p), 64'(e.p));
    chk($sformatf("sb_pcout%0d", inst), 64'(pc), 64'(e.p));
    chk($sformatf("sb_carryout%0d", inst), 64'(co), 64'(e.co));
    chk($sformatf("sb_m%0d", inst), 64'(mp), 64'(e.m));
  endtask

  always @(posedge clk) adv <= rstn && !stall;

  // Monitor: one pop per OUT_VALID pulse; M is taken from the cycle before P updated
  always @(negedge clk) begin
    if (rstn && adv) begin
      if (ov0) mon(0, p0, pcout0, co0, mprev0);
      if (ov1) mon(1, p1, pcout1, co1, mprev1);
    end
    mprev0 = m0;
    mprev1 = m1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    smp_t s20, acc, sat, brw, s, idle;
    logic [PW-1:0] exp_p;
    s20  = mk(20, 10, 25, 350, 8'b1101_1101);
    acc  = mk(3, 4, 0, 0, 8'b0000_1001);
    sat  = mk(1, 1, 0, 64'(ALL1), 8'b0001_1101);
    brw  = mk(2, 3, 0, 5, 8'b1000_1101);
    idle = mk(0, 0, 0, 0, 8'h00);

    do_reset();
    chk("reset_p", 64'(p0), 64'(0));
    chk("reset_out_valid", 64'(ov1), 64'(0));
    chk("reset_ovf", 64'(ovf1), 64'(0));

    // Basic path
    step(1, 0, 0, s20);
    step(0, 0, 0, s20);
    chk("basic_bcout0", 64'(bcout0), 64'(15));
    chk("basic_bcout1", 64'(bcout1), 64'(15));
    step(0, 0, 0, s20);
    chk("basic_m", 64'(m0), 64'(300));
    chk("basic_ov_early", 64'(ov0), 64'(0));
    step(0, 0, 0, s20);
    chk("basic_p0", 64'(p0), 64'(50));
    chk("basic_pcout0", 64'(pcout0), 64'(50));
    chk("basic_co0", 64'(co0), 64'(0));
    chk("basic_ov0", 64'(ov0), 64'(1));
    chk("basic_p1", 64'(p1), 64'(50));
    step(0, 0, 0, s20);
    chk("basic_ov_single", 64'(ov0), 64'(0));

    // Accumulate from P=0 after reset
    do_reset();
    repeat (3) step(1, 0, 0, acc);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, acc);
      exp_p = (i < 3) ? PW'(12 * (i + 1)) : PW'(36);
      chk($sformatf("accum_p0_%0d", i), 64'(p0), 64'(exp_p));
      chk($sformatf("accum_p1_%0d", i), 64'(p1), 64'(exp_p));
      chk($sformatf("accum_ov_%0d", i), 64'(ov0), 64'(i < 3));
    end

    // Saturating add, then clear coinciding with a second clamp
    step(1, 0, 0, sat);
    repeat (3) step(0, 0, 0, sat);
    chk("sat_p1", 64'(p1), 64'(ALL1));
    chk("sat_co1", 64'(co1), 64'(1));
    chk("sat_ovf1", 64'(ovf1), 64'(1));
    chk("wrap_p0", 64'(p0), 64'(0));
    chk("wrap_co0", 64'(co0), 64'(1));
    chk("wrap_ovf0", 64'(ovf0), 64'(0));
    step(1, 0, 0, sat);
    repeat (2) step(0, 0, 0, sat);
    step(0, 0, 1, sat);
    chk("sat_clr_set_wins", 64'(ovf1), 64'(1));
    chk("sat_clr_ov1", 64'(ov1), 64'(1));
    step(0, 0, 1, sat);
    chk("sat_clr_only", 64'(ovf1), 64'(0));

    // Subtract with borrow
    step(1, 0, 0, brw);
    repeat (3) step(0, 0, 0, brw);
    chk("borrow_p1", 64'(p1), 64'(0));
    chk("borrow_co1", 64'(co1), 64'(1));
    chk("borrow_ovf1", 64'(ovf1), 64'(1));
    chk("borrow_p0", 64'(p0), 64'(ALL1));
    chk("borrow_co0", 64'(co0), 64'(1));

    // Three-cycle stall one cycle after the sample enters
    do_reset();
    step(0, 0, 0, mk(5, 7, 0, 0, 8'h00));
    step(1, 0, 0, s20);
    step(0, 0, 0, s20);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, s20);
      chk($sformatf("stall_bcout_%0d", i), 64'(bcout0), 64'(15));
      chk($sformatf("stall_m_%0d", i), 64'(m0), 64'(35));
      chk($sformatf("stall_ov_%0d", i), 64'(ov0), 64'(0));
    end
    step(0, 0, 0, s20);
    chk("stall_m_after", 64'(m0), 64'(300));
    chk("stall_ov_c6", 64'(ov0), 64'(0));
    step(0, 0, 0, s20);
    chk("stall_ov_c7", 64'(ov0), 64'(1));
    chk("stall_p", 64'(p0), 64'(50));
    step(0, 0, 0, s20);

    // Reset with two samples in flight
    step(1, 0, 0, s20);
    step(1, 0, 0, acc);
    #2;
    rstn = 1'b0;
    in_valid = 1'b0;
    flush_model();
    #1;
    chk("rst_bcout", 64'(bcout0 | bcout1), 64'(0));
    chk("rst_m", 64'(m0 | m1), 64'(0));
    chk("rst_p", 64'(p0 | p1 | pcout0 | pcout1), 64'(0));
    chk("rst_flags", 64'({co0, co1, ov0, ov1, ovf0, ovf1}), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, idle);
      chk($sformatf("rst_no_ov_%0d", i), 64'({ov0, ov1}), 64'(0));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s.a = AW'($urandom);
      s.b = BW'($urandom);
      s.d = BW'($urandom);
      case ($urandom_range(0, 3))
        0:       s.c = ALL1;
        1:       s.c = PW'($urandom_range(0, 1000));
        default: s.c = PW'({$urandom, $urandom});
      endcase
      s.pcin = PW'({$urandom, $urandom});
      s.op   = 8'($urandom);
      s.cin  = 1'($urandom);
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20, 0, s);
    end
    for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) begin
      step(0, 0, 0, idle);
    end
    chk("drain_q0", 64'(q0.size()), 64'(0));
    chk("drain_q1", 64'(q1.size()), 64'(0));
    chk("rand_ovf1", 64'(ovf1), 64'(sticky1));
    chk("rand_ovf0", 64'(ovf0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 The block SHALL take these parameters:
- AW, 18, A operand width.
- BW, 18, B/D operand and pre-adder width.
- PW, 48, post-adder, C, PCIN and P width; PW >= AW+BW.
- CARRYINSEL, 0, carry source: 0 = OPMODE[5], 1 = CARRYIN port.
- SAT, 0, post-adder mode: 0 = wrap, 1 = saturate.

REQ-002 The block SHALL have these ports:
- CLK  in  1  single clock; all registers rising-edge.
- RSTN  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  input sample valid.
- STALL  in  1  freeze the whole pipeline.
- A  in  AW  multiplier operand.
- B  in  BW  pre-adder operand.
- D  in  BW  pre-adder operand.
- C  in  PW  post-adder operand.
- PCIN  in  PW  cascade input.
- OPMODE  in  8  per-sample mode, carried with the data.
- CARRYIN  in  1  external carry.
- CLR_OVF  in  1  clear the sticky overflow flag.
- BCOUT  out  BW  stage-2 pre-adder register.
- M  out  AW+BW  stage-3 multiplier register.
- P  out  PW  stage-4 result register.
- PCOUT  out  PW  copy of P.
- CARRYOUT  out  1  raw post-adder carry/borrow.
- OUT_VALID  out  1  P holds a new sample.
- OVF  out  1  sticky saturation flag.

Function
REQ-003 The block SHALL be a 4-stage pipeline with these stages:
- S1 registers A, B, D, C, PCIN, OPMODE, CARRYIN and IN_VALID.
- S2 produces BCOUT.
- S3 produces M.
- S4 produces P and CARRYOUT.

REQ-004 OPMODE and valid SHALL travel through the pipeline with their sample. Each stage SHALL use the OPMODE captured with its own sample, never the live port value.

REQ-005 S2 SHALL compute BCOUT as follows, modulo 2^BW:
- OPMODE[4]=0: BCOUT = B.
- OPMODE[4]=1 and OPMODE[6]=1: BCOUT = D-B.
- OPMODE[4]=1 and OPMODE[6]=0: BCOUT = D+B.

REQ-006 S3 SHALL compute M = BCOUT*A, unsigned, full AW+BW bits, with no truncation.

REQ-007 The X mux SHALL be selected by OPMODE[1:0]:
- 0: X = 0.
- 1: X = M, zero-extended.
- 2: X = P.
- 3: X = C.

REQ-008 The Z mux SHALL be selected by OPMODE[3:2]:
- 0: Z = 0.
- 1: Z = PCIN.
- 2: Z = P.
- 3: Z = C.

REQ-009 The S4 computation SHALL be done in PW+1 bits:
- CIN is the carry selected by CARRYINSEL.
- OPMODE[7]=0: {CARRYOUT,raw} = Z + X + CIN.
- OPMODE[7]=1: {CARRYOUT,raw} = Z - (X + CIN).

REQ-010 The result written to P SHALL depend on SAT:
- SAT=0: P = raw.
- SAT=1, CARRYOUT=1 on an add: P = all ones.
- SAT=1, CARRYOUT=1 on a subtract: P = 0.
- SAT=1, CARRYOUT=0: P = raw.
- CARRYOUT SHALL always report the raw carry.

REQ-011 P, PCOUT and CARRYOUT SHALL update only on a cycle where the S3 valid is 1 and STALL=0. Otherwise they hold, so that X=P or Z=P accumulates only valid samples.

REQ-012 OUT_VALID SHALL be high for exactly one cycle per accepted sample, 4 cycles after IN_VALID=1 is sampled with STALL=0 throughout.

REQ-013 When STALL=1, every pipeline register, the valid bits and OUT_VALID SHALL hold their values. Latency grows by the number of stalled cycles, and no sample is lost or duplicated.

REQ-014 BCOUT and M SHALL advance every non-stalled cycle regardless of valid.

REQ-015 OVF SHALL behave as follows:
- Set when SAT=1 and a clamp occurs on a P update.
- Cleared by CLR_OVF=1.
- If set and clear occur in the same cycle, set wins.
- Held during STALL.

REQ-016 With SAT=0, OVF SHALL stay 0.

Reset
REQ-017 RSTN=0 SHALL immediately, without a clock edge, force to 0: all pipeline registers, valid bits, BCOUT, M, P, PCOUT, CARRYOUT, OUT_VALID and OVF.

REQ-018 Samples in flight at reset SHALL be discarded, and no OUT_VALID SHALL appear for them.

REQ-019 The first sample accepted after RSTN rises SHALL see P = 0 as its feedback value.

Verification
REQ-020 Basic path: A=20, B=10, D=25, C=350, OPMODE=8'b1101_1101, one valid sample -> 4 cycles later BCOUT=15, M=300, P=PCOUT=50, CARRYOUT=0, OUT_VALID pulses for 1 cycle.

REQ-021 Accumulate: after reset, OPMODE=8'b0000_1001, A=3, B=4, three consecutive valid samples, then IN_VALID=0 for 5 cycles -> P=12, 24, 36 on successive OUT_VALID pulses, then P holds 36.

REQ-022 Saturation, SAT=1: C=2^48-1, A=1, B=1, OPMODE=8'b0001_1101 -> P=2^48-1, CARRYOUT=1, OVF=1. Then CLR_OVF=1 together with a clamping sample -> OVF stays 1.

REQ-023 Borrow: C=5, A=2, B=3 (M=6), OPMODE=8'b1000_1101 -> SAT=1: P=0, CARRYOUT=1. SAT=0: P=2^48-1, CARRYOUT=1.

REQ-024 Stall: STALL=1 for 3 cycles, one cycle after a valid sample enters -> OUT_VALID arrives at cycle 7 instead of 4, with the correct P, and BCOUT/M frozen during the stall.

REQ-025 Reset mid-operation: two samples in flight, RSTN pulled low between clock edges -> all outputs 0 before the next edge, and no OUT_VALID after RSTN releases.
